// File: rtl/press_decoder.sv
// Classifies debounced presses into short/long/double (and optional auto-repeat) single-cycle pulses.
// Optional feature: define PRESS_DECODER_AUTOREPEAT_EN for repeat_tick while held after a long press.
module press_decoder #(
    parameter int CLK_DIV   = 50000,
    parameter int LONG_MS   = 800,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    input  logic db_tick,
    output logic short_tick,
    output logic long_tick,
    output logic double_tick,
    output logic repeat_tick,
    output logic busy
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (LONG_MS >= 2**CNT_W || DOUBLE_MS >= 2**CNT_W || REPEAT_MS >= 2**CNT_W) begin : g_cfg_check
        $error("press_decoder: CNT_W too narrow for the configured thresholds");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_PRESS2,
        S_HELD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PRE_W-1:0] r_presc;
    logic [CNT_W-1:0] r_ms_cnt;
    logic             w_ms_tick;
    logic             w_long_to;
    logic             w_double_to;
    logic             w_restart;
    logic             w_short;
    logic             w_long;
    logic             w_double;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_busy;

    assign w_ms_tick   = (r_presc == PRE_W'(CLK_DIV - 1));
    assign w_long_to   = w_ms_tick && (r_ms_cnt == CNT_W'(LONG_MS - 1));
    assign w_double_to = w_ms_tick && (r_ms_cnt == CNT_W'(DOUBLE_MS - 1));

`ifdef PRESS_DECODER_AUTOREPEAT_EN
    logic w_rep_to;
    logic w_repeat;
    logic r_repeat;

    assign w_rep_to    = w_ms_tick && (r_ms_cnt == CNT_W'(REPEAT_MS - 1));
    assign repeat_tick = r_repeat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat;
        end
    end
`else
    assign repeat_tick = 1'b0;
`endif

    // Priority within each state: release / new tick beats a coincident timeout.
    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        w_short   = 1'b0;
        w_long    = 1'b0;
        w_double  = 1'b0;
`ifdef PRESS_DECODER_AUTOREPEAT_EN
        w_repeat  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (db_tick) w_next = S_PRESS1;
            end
            S_PRESS1: begin
                if (!db_level) begin
                    w_next = S_GAP;
                end else if (w_long_to) begin
                    w_next = S_HELD;
                    w_long = 1'b1;
                end
            end
            S_GAP: begin
                if (db_tick) begin
                    w_next = S_PRESS2;
                end else if (w_double_to) begin
                    w_next  = S_IDLE;
                    w_short = 1'b1;
                end
            end
            S_PRESS2: begin
                if (!db_level) begin
                    w_next   = S_IDLE;
                    w_double = 1'b1;
                end
            end
            S_HELD: begin
                if (!db_level) begin
                    w_next = S_IDLE;
                end
`ifdef PRESS_DECODER_AUTOREPEAT_EN
                else if (w_rep_to) begin
                    w_restart = 1'b1;
                    w_repeat  = 1'b1;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timebase restarts on every state change so each state is timed from its entry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_ms_cnt <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_short  <= w_short;
            r_long   <= w_long;
            r_double <= w_double;
            r_busy   <= (w_next != S_IDLE);
            if ((w_next != r_state) || w_restart) begin
                r_presc  <= '0;
                r_ms_cnt <= '0;
            end else if (w_ms_tick) begin
                r_presc <= '0;
                if (r_ms_cnt != '1) r_ms_cnt <= r_ms_cnt + CNT_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    assign short_tick  = r_short;
    assign long_tick   = r_long;
    assign double_tick = r_double;
    assign busy        = r_busy;

endmodule
